// File: rtl/led_flash_monitor_pkg.sv
// Shared definitions for the LED flash monitor: classifier state codes,
// phase codes and a width helper.
package led_flash_monitor_pkg;

    // Classifier state encodings
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RED_UP = 3'd1;
    localparam logic [2:0] S_RED_DN = 3'd2;
    localparam logic [2:0] S_GRN_UP = 3'd3;
    localparam logic [2:0] S_GRN_DN = 3'd4;

    // Externally visible phase codes
    localparam logic [1:0] PH_RED_UP = 2'd0;
    localparam logic [1:0] PH_RED_DN = 2'd1;
    localparam logic [1:0] PH_GRN_UP = 2'd2;
    localparam logic [1:0] PH_GRN_DN = 2'd3;

    // Number of bits needed to hold the unsigned value (at least 1)
    function automatic int unsigned numBits(input int unsigned value);
        int unsigned bits;
        bits = 1;
        while ((value >> bits) != 0) bits++;
        return bits;
    endfunction

endpackage

// File: rtl/led_flash_monitor_if.sv
// Drive lines from the flasher plus the measurement/classification results.
interface led_flash_monitor_if #(
    parameter int unsigned CW = 4
);
    logic          red_n;
    logic          green_n;
    logic [CW-1:0] red_duty;
    logic [CW-1:0] green_duty;
    logic          duty_valid;
    logic [1:0]    phase;
    logic          phase_valid;
    logic          seq_err;
    logic          conflict;

    // Flasher / bench side
    modport master (
        output red_n, green_n,
        input  red_duty, green_duty, duty_valid, phase, phase_valid, seq_err, conflict
    );

    // Monitor side
    modport slave (
        input  red_n, green_n,
        output red_duty, green_duty, duty_valid, phase, phase_valid, seq_err, conflict
    );
endinterface

// File: rtl/led_ontime_counter.sv
// Per-colour on-time counter: counts lit samples over a window, latches the
// total (including the terminal-count sample) and restarts at window end.
module led_ontime_counter #(
    parameter int unsigned CW = 4
) (
    input  logic          Clk,
    input  logic          ResetN,
    input  logic          inc,
    input  logic          tc,
    output logic [CW-1:0] duty
);
    logic [CW-1:0] cnt;
    logic [CW-1:0] next_cnt;

    // Saturating increment of the running count
    always_comb begin
        next_cnt = cnt;
        if (inc && cnt != '1) next_cnt = cnt + 1'b1;
    end

    // Accumulate, or latch and clear on terminal count
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            cnt  <= '0;
            duty <= '0;
        end else begin
            assert (!(inc && cnt == '1));
            if (tc) begin
                duty <= next_cnt;
                cnt  <= '0;
            end else begin
                cnt <= next_cnt;
            end
        end
    end
endmodule

// File: rtl/led_flash_monitor.sv
// Self-test receiver for the bicolour LED flasher: measures per-window on-time
// of each colour and classifies the breathing phase sequence.
module led_flash_monitor
    import led_flash_monitor_pkg::*;
#(
    parameter int unsigned WIN_LEN = 8,
    parameter int unsigned CW      = 4
) (
    input logic                Clk,
    input logic                ResetN,
    led_flash_monitor_if.slave bus
);
    localparam int unsigned     WCW      = numBits(WIN_LEN - 1);
    localparam logic [WCW-1:0]  WIN_LOAD = WCW'(WIN_LEN - 1);

    logic           r_on;
    logic           g_on;
    logic [WCW-1:0] win_cnt;
    logic           tc;
    logic [CW-1:0]  red_duty;
    logic [CW-1:0]  green_duty;
    logic [CW-1:0]  prev_red;
    logic [CW-1:0]  prev_green;
    logic           duty_valid;
    logic [2:0]     state;
    logic [2:0]     nxt_state;
    logic           both_lit;
    logic           in_order;
    logic           seq_err;
    logic           conflict;
    logic [1:0]     phase;

    // Register and invert the active-low drive lines
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_on <= 1'b0;
            g_on <= 1'b0;
        end else begin
            r_on <= ~bus.red_n;
            g_on <= ~bus.green_n;
        end
    end

    // Free-running down-counting window timer; duty_valid trails terminal count
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            win_cnt    <= WIN_LOAD;
            duty_valid <= 1'b0;
        end else begin
            win_cnt    <= tc ? WIN_LOAD : win_cnt - 1'b1;
            duty_valid <= tc;
        end
    end

    assign tc = (win_cnt == '0);

    led_ontime_counter #(.CW(CW)) u_red_cnt (
        .Clk    (Clk),
        .ResetN (ResetN),
        .inc    (r_on),
        .tc     (tc),
        .duty   (red_duty)
    );

    led_ontime_counter #(.CW(CW)) u_green_cnt (
        .Clk    (Clk),
        .ResetN (ResetN),
        .inc    (g_on),
        .tc     (tc),
        .duty   (green_duty)
    );

    assign both_lit = (red_duty != '0) && (green_duty != '0);

    // Classify the latched window and judge whether the move is in sequence
    always_comb begin
        nxt_state = state;
        if (!both_lit && red_duty != '0) begin
            if (red_duty > prev_red)      nxt_state = S_RED_UP;
            else if (red_duty < prev_red) nxt_state = S_RED_DN;
            else if (state == S_IDLE)     nxt_state = S_RED_UP;
        end else if (!both_lit && green_duty != '0) begin
            if (green_duty > prev_green)      nxt_state = S_GRN_UP;
            else if (green_duty < prev_green) nxt_state = S_GRN_DN;
            else if (state == S_IDLE)         nxt_state = S_GRN_UP;
        end

        in_order = (nxt_state == state);
        case (state)
            S_IDLE:   in_order = 1'b1;
            S_RED_UP: if (nxt_state == S_RED_DN) in_order = 1'b1;
            S_RED_DN: if (nxt_state == S_GRN_UP) in_order = 1'b1;
            S_GRN_UP: if (nxt_state == S_GRN_DN) in_order = 1'b1;
            S_GRN_DN: if (nxt_state == S_RED_UP) in_order = 1'b1;
            default:  ;
        endcase
    end

    // Advance the classifier once per completed window; conflicts freeze history
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state      <= S_IDLE;
            prev_red   <= '0;
            prev_green <= '0;
            seq_err    <= 1'b0;
            conflict   <= 1'b0;
        end else begin
            seq_err  <= 1'b0;
            conflict <= 1'b0;
            if (duty_valid) begin
                if (both_lit) begin
                    conflict <= 1'b1;
                end else begin
                    state      <= nxt_state;
                    seq_err    <= ~in_order;
                    prev_red   <= red_duty;
                    prev_green <= green_duty;
                end
            end
        end
    end

    // Map classifier state onto the phase code (IDLE reads as 0)
    always_comb begin
        case (state)
            S_RED_DN: phase = PH_RED_DN;
            S_GRN_UP: phase = PH_GRN_UP;
            S_GRN_DN: phase = PH_GRN_DN;
            default:  phase = PH_RED_UP;
        endcase
    end

    assign bus.red_duty    = red_duty;
    assign bus.green_duty  = green_duty;
    assign bus.duty_valid  = duty_valid;
    assign bus.phase       = phase;
    assign bus.phase_valid = (state != S_IDLE);
    assign bus.seq_err     = seq_err;
    assign bus.conflict    = conflict;
endmodule

// File: tb/tb_led_flash_monitor.sv
// Directed and randomized bench for led_flash_monitor with a window-level
// reference model of on-time measurement and phase classification.
module tb_led_flash_monitor;
    localparam int unsigned WIN_LEN = 8;
    localparam int unsigned CW      = 4;

    logic Clk = 1'b0;
    logic ResetN;

    always #5 Clk = ~Clk;

    led_flash_monitor_if #(.CW(CW)) bus ();

    led_flash_monitor #(.WIN_LEN(WIN_LEN), .CW(CW)) dut (
        .Clk    (Clk),
        .ResetN (ResetN),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: sample pipeline, window position, duties, phase history
    int m_smp_r, m_smp_g, m_pos, m_acc_r, m_acc_g, m_dv, m_rd, m_gd;
    int m_prev_r, m_prev_g, m_idle, m_ph, m_seq, m_conf;

    int obs_red[$];
    int obs_green[$];
    int obs_phase[$];
    int n_seq, n_conf;
    bit last_dv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_smp_r = 0; m_smp_g = 0; m_pos = 0; m_acc_r = 0; m_acc_g = 0;
        m_dv = 0; m_rd = 0; m_gd = 0; m_prev_r = 0; m_prev_g = 0;
        m_idle = 1; m_ph = 0; m_seq = 0; m_conf = 0;
        obs_red.delete(); obs_green.delete(); obs_phase.delete();
        n_seq = 0; n_conf = 0; last_dv = 1'b0;
    endtask

    // One rising edge of the model: classify the window reported last cycle,
    // then account for the current sample and the newly registered input.
    task automatic model_edge(input logic rn, input logic gn);
        int np;
        m_seq  = 0;
        m_conf = 0;
        if (m_dv != 0) begin
            if (m_rd > 0 && m_gd > 0) begin
                m_conf = 1;
            end else begin
                np = m_ph;
                if (m_rd > 0)
                    np = (m_rd > m_prev_r) ? 0 : (m_rd < m_prev_r) ? 1 : (m_idle != 0 ? 0 : m_ph);
                else if (m_gd > 0)
                    np = (m_gd > m_prev_g) ? 2 : (m_gd < m_prev_g) ? 3 : (m_idle != 0 ? 2 : m_ph);
                if (m_rd > 0 || m_gd > 0) begin
                    m_seq  = (m_idle == 0 && np != m_ph && np != (m_ph + 1) % 4) ? 1 : 0;
                    m_ph   = np;
                    m_idle = 0;
                end
                m_prev_r = m_rd;
                m_prev_g = m_gd;
            end
        end
        m_acc_r += m_smp_r;
        m_acc_g += m_smp_g;
        m_pos++;
        if (m_pos == int'(WIN_LEN)) begin
            m_rd = m_acc_r; m_gd = m_acc_g;
            m_acc_r = 0; m_acc_g = 0; m_pos = 0;
            m_dv = 1;
        end else begin
            m_dv = 0;
        end
        m_smp_r = (rn == 1'b0) ? 1 : 0;
        m_smp_g = (gn == 1'b0) ? 1 : 0;
    endtask

    task automatic step(input logic rn, input logic gn);
        bus.red_n   = rn;
        bus.green_n = gn;
        @(posedge Clk);
        #1;
        model_edge(rn, gn);
        chk("duty_valid",  32'(bus.duty_valid),  m_dv);
        chk("red_duty",    32'(bus.red_duty),    m_rd);
        chk("green_duty",  32'(bus.green_duty),  m_gd);
        chk("phase",       32'(bus.phase),       m_ph);
        chk("phase_valid", 32'(bus.phase_valid), (m_idle != 0) ? 0 : 1);
        chk("seq_err",     32'(bus.seq_err),     m_seq);
        chk("conflict",    32'(bus.conflict),    m_conf);
        if (bus.duty_valid === 1'b1) begin
            obs_red.push_back(int'(bus.red_duty));
            obs_green.push_back(int'(bus.green_duty));
        end
        if (last_dv) obs_phase.push_back(int'(bus.phase));
        if (bus.seq_err === 1'b1) n_seq++;
        if (bus.conflict === 1'b1) n_conf++;
        last_dv = (bus.duty_valid === 1'b1);
        @(negedge Clk);
    endtask

    // Drive one window of WIN_LEN cycles with r/g contiguous lit runs at random
    // offsets inside the first WIN_LEN-1 cycles, so each run lands in one window.
    task automatic window(input int r, input int g, input bit same);
        int span;
        int ro;
        int go;
        span = int'(WIN_LEN) - 1;
        ro = int'($urandom_range(32'(span - r), 0));
        go = same ? ro : int'($urandom_range(32'(span - g), 0));
        for (int i = 0; i < int'(WIN_LEN); i++)
            step(!(i >= ro && i < ro + r), !(i >= go && i < go + g));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_red_duty"},    32'(bus.red_duty),    0);
        chk({tag, "_green_duty"},  32'(bus.green_duty),  0);
        chk({tag, "_duty_valid"},  32'(bus.duty_valid),  0);
        chk({tag, "_phase"},       32'(bus.phase),       0);
        chk({tag, "_phase_valid"}, 32'(bus.phase_valid), 0);
        chk({tag, "_seq_err"},     32'(bus.seq_err),     0);
        chk({tag, "_conflict"},    32'(bus.conflict),    0);
    endtask

    task automatic do_reset();
        bus.red_n   = 1'b1;
        bus.green_n = 1'b1;
        ResetN      = 1'b0;
        #1;
        check_zero("reset");
        @(negedge Clk);
        @(negedge Clk);
        model_reset();
        ResetN = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int r;
        int g;
        bit seen;

        ResetN      = 1'b0;
        bus.red_n   = 1'b1;
        bus.green_n = 1'b1;
        model_reset();
        @(negedge Clk);

        // Red held lit: first window loses the stale reset sample
        do_reset();
        repeat (3 * WIN_LEN + 1) step(1'b0, 1'b1);
        chk("hold_red_w0", 32'(obs_red[0]), 7);
        chk("hold_red_w1", 32'(obs_red[1]), 8);
        chk("hold_red_w2", 32'(obs_red[2]), 8);
        chk("hold_phase", 32'(bus.phase), 0);
        chk("hold_phase_valid", 32'(bus.phase_valid), 1);
        chk("hold_seq_cnt", 32'(n_seq), 0);

        // Red ramp 2,4,6 then 3
        do_reset();
        window(2, 0, 1'b0);
        window(4, 0, 1'b0);
        window(6, 0, 1'b0);
        window(3, 0, 1'b0);
        window(0, 0, 1'b0);
        chk("ramp_red_w3", 32'(obs_red[3]), 3);
        chk("ramp_ph0", 32'(obs_phase[0]), 0);
        chk("ramp_ph2", 32'(obs_phase[2]), 0);
        chk("ramp_ph3", 32'(obs_phase[3]), 1);
        chk("ramp_seq_cnt", 32'(n_seq), 0);

        // Full breathing cycle back to red up
        do_reset();
        window(2, 0, 1'b0);
        window(5, 0, 1'b0);
        window(3, 0, 1'b0);
        window(0, 2, 1'b0);
        window(0, 5, 1'b0);
        window(0, 3, 1'b0);
        window(4, 0, 1'b0);
        window(0, 0, 1'b0);
        chk("cycle_ph_rd", 32'(obs_phase[2]), 1);
        chk("cycle_ph_gu", 32'(obs_phase[4]), 2);
        chk("cycle_ph_gd", 32'(obs_phase[5]), 3);
        chk("cycle_ph_ru", 32'(obs_phase[6]), 0);
        chk("cycle_seq_cnt", 32'(n_seq), 0);

        // Skip from red up straight to green up, then a conflict window,
        // then green down ahead of a mid-window reset
        do_reset();
        window(3, 0, 1'b0);
        window(0, 2, 1'b0);
        window(0, 5, 1'b0);
        window(3, 3, 1'b1);
        window(0, 3, 1'b0);
        chk("skip_ph1", 32'(obs_phase[1]), 2);
        chk("skip_ph2", 32'(obs_phase[2]), 2);
        chk("skip_seq_cnt", 32'(n_seq), 1);
        chk("conf_red_duty", 32'(obs_red[3]), 3);
        chk("conf_green_duty", 32'(obs_green[3]), 3);
        chk("conf_phase_held", 32'(obs_phase[3]), 2);
        chk("conf_cnt", 32'(n_conf), 1);
        repeat (3) step(1'b1, 1'b0);
        chk("pre_reset_phase", 32'(bus.phase), 3);

        // Asynchronous reset mid-window clears outputs immediately
        ResetN = 1'b0;
        #1;
        check_zero("mid_reset");
        @(negedge Clk);
        model_reset();
        ResetN = 1'b1;
        bus.red_n   = 1'b1;
        bus.green_n = 1'b1;
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 3 * int'(WIN_LEN) && !seen; k++) begin
            step(1'b1, 1'b1);
            if (last_dv) begin
                lat  = k;
                seen = 1'b1;
            end
        end
        // duty_valid rises on edge WIN_LEN, i.e. is high in cycle WIN_LEN+1
        chk("rst_to_dv_cycles", 32'(lat + 1), 32'(WIN_LEN + 1));

        // Randomized windows against the model
        do_reset();
        for (int w = 0; w < 16; w++) begin
            r = int'($urandom_range(7, 0));
            g = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 0)) : 0;
            if (g > 0 && $urandom_range(1, 0) == 1) r = 0;
            window(r, g, 1'b0);
        end
        window(0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
